// File: rtl/riscv_def.sv
// ---------------------------------------------------------------------------
// riscv_def
// Shared definitions for the write-back stage of the pipelined RISC-V core.
// Contents:
//   WB_SEL_*     result source select codes driven by the decoder
//   LOAD_SIZE_*  load access size codes
//   wb_state_e   write-back FSM state encodings
// ---------------------------------------------------------------------------
package riscv_def;

    // Result source for the register-file write data.
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    localparam logic [1:0] WB_SEL_CSR = 2'd3;

    // Load access size.
    localparam logic [1:0] LOAD_SIZE_B = 2'd0;
    localparam logic [1:0] LOAD_SIZE_H = 2'd1;
    localparam logic [1:0] LOAD_SIZE_W = 2'd2;
    localparam logic [1:0] LOAD_SIZE_D = 2'd3;

    // IDLE: ready for a new instruction.
    // WAIT_MEM: a load is waiting for its read response.
    // DRAIN: a flushed load's response is still in flight and must be eaten.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_DRAIN    = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// ---------------------------------------------------------------------------
// load_align
// Combinational load-data aligner. Shifts the raw read word down by the byte
// offset, keeps the low 8/16/32/64 bits according to the access size and
// sign- or zero-extends the result to DATA_WIDTH.
// Ports:
//   rdata          raw read word from data memory
//   offset         byte offset of the load within the word
//   size           access size (LOAD_SIZE_* codes)
//   load_unsigned  1 = zero-extend, 0 = sign-extend
//   data_out       aligned and extended load value
// ---------------------------------------------------------------------------
module load_align
    import riscv_def::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [OFF_W-1:0]      offset,
    input  logic [1:0]            size,
    input  logic                  load_unsigned,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] keep_mask;
    logic                  sign_bit;

    // Bytes above the top of the word shift in as zero, which is how
    // misaligned accesses are handled (no trap).
    assign shifted = rdata >> {offset, 3'b000};

    // A doubleword on a 32-bit datapath collapses to a full-word access,
    // which is why the D case uses the top bit of whatever width we have.
    always_comb begin
        keep_mask = '1;
        sign_bit  = shifted[DATA_WIDTH-1];
        case (size)
            LOAD_SIZE_B: begin
                keep_mask = DATA_WIDTH'(8'hFF);
                sign_bit  = shifted[7];
            end
            LOAD_SIZE_H: begin
                keep_mask = DATA_WIDTH'(16'hFFFF);
                sign_bit  = shifted[15];
            end
            LOAD_SIZE_W: begin
                keep_mask = DATA_WIDTH'(32'hFFFF_FFFF);
                sign_bit  = shifted[31];
            end
            default: begin
                keep_mask = '1;
                sign_bit  = shifted[DATA_WIDTH-1];
            end
        endcase
    end

    // Bits outside the kept field are filled with the sign bit for signed
    // loads; for a full-width access the fill mask is empty.
    always_comb begin
        if (load_unsigned) begin
            data_out = shifted & keep_mask;
        end else begin
            data_out = (shifted & keep_mask) | (~keep_mask & {DATA_WIDTH{sign_bit}});
        end
    end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Write-back stage. Accepts one retiring instruction per cycle from MEM,
// waits for variable-latency load responses, aligns load data, selects the
// result source and drives a registered register-file write port (which is
// also the forwarding source). Responses belonging to a flushed load are
// drained and dropped.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   handshake with MEM
//   in_regwrite, in_rd  destination write enable and index
//   in_wb_sel           result source (WB_SEL_* codes)
//   in_alu_data, in_pc_plus4, in_csr_data   non-load result candidates
//   in_load_size, in_load_unsigned, in_addr_lo   load formatting info
//   flush               kill the current or pending instruction
//   mem_rvalid, mem_rdata   data-memory read response
//   rf_we, rf_waddr, rf_wdata   registered register-file write port
//   busy                a load is outstanding or being drained
// ---------------------------------------------------------------------------
module wb_stage
    import riscv_def::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int REG_ADDR_WIDTH = 5,
    localparam int OFF_W          = $clog2(DATA_WIDTH / 8)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_regwrite,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [1:0]                in_wb_sel,
    input  logic [DATA_WIDTH-1:0]     in_alu_data,
    input  logic [DATA_WIDTH-1:0]     in_pc_plus4,
    input  logic [DATA_WIDTH-1:0]     in_csr_data,
    input  logic [1:0]                in_load_size,
    input  logic                      in_load_unsigned,
    input  logic [OFF_W-1:0]          in_addr_lo,
    input  logic                      flush,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      busy
);

    wb_state_e                 state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] pend_rd_q, pend_rd_d;
    logic                      pend_regwrite_q, pend_regwrite_d;
    logic [1:0]                pend_size_q, pend_size_d;
    logic                      pend_unsigned_q, pend_unsigned_d;
    logic [OFF_W-1:0]          pend_off_q, pend_off_d;

    logic                      rf_we_q, rf_we_d;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;

    logic                      accept;
    logic [DATA_WIDTH-1:0]     sel_data;
    logic [DATA_WIDTH-1:0]     align_data;
    logic [OFF_W-1:0]          align_off;
    logic [1:0]                align_size;
    logic                      align_unsigned;

    assign in_ready = (state_q == ST_IDLE) & ~rst;
    assign busy     = (state_q != ST_IDLE);
    assign accept   = in_valid & in_ready;

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // One aligner serves both paths: in IDLE a same-cycle response is
    // formatted with the incoming fields, while waiting the latched ones apply.
    always_comb begin
        if (state_q == ST_WAIT_MEM) begin
            align_off      = pend_off_q;
            align_size     = pend_size_q;
            align_unsigned = pend_unsigned_q;
        end else begin
            align_off      = in_addr_lo;
            align_size     = in_load_size;
            align_unsigned = in_load_unsigned;
        end
    end

    load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata         (mem_rdata),
        .offset        (align_off),
        .size          (align_size),
        .load_unsigned (align_unsigned),
        .data_out      (align_data)
    );

    // Non-load result source. The MEM code never reaches this mux's output
    // because loads always write the aligned data instead.
    always_comb begin
        case (in_wb_sel)
            WB_SEL_PC4: sel_data = in_pc_plus4;
            WB_SEL_CSR: sel_data = in_csr_data;
            default:    sel_data = in_alu_data;
        endcase
    end

    // Next-state and write-port logic. rf_we defaults low so it is a one-cycle
    // pulse per completion; address and data hold their last written values.
    // Writes to x0 still complete (and still wait for a load response) but
    // never raise the enable.
    always_comb begin
        state_d         = state_q;
        pend_rd_d       = pend_rd_q;
        pend_regwrite_d = pend_regwrite_q;
        pend_size_d     = pend_size_q;
        pend_unsigned_d = pend_unsigned_q;
        pend_off_d      = pend_off_q;
        rf_we_d         = 1'b0;
        rf_waddr_d      = rf_waddr_q;
        rf_wdata_d      = rf_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && !flush) begin
                    if (in_wb_sel != WB_SEL_MEM) begin
                        rf_we_d    = in_regwrite & (in_rd != '0);
                        rf_waddr_d = in_rd;
                        rf_wdata_d = sel_data;
                    end else if (mem_rvalid) begin
                        rf_we_d    = in_regwrite & (in_rd != '0);
                        rf_waddr_d = in_rd;
                        rf_wdata_d = align_data;
                    end else begin
                        pend_rd_d       = in_rd;
                        pend_regwrite_d = in_regwrite;
                        pend_size_d     = in_load_size;
                        pend_unsigned_d = in_load_unsigned;
                        pend_off_d      = in_addr_lo;
                        state_d         = ST_WAIT_MEM;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rvalid) begin
                    if (!flush) begin
                        rf_we_d    = pend_regwrite_q & (pend_rd_q != '0);
                        rf_waddr_d = pend_rd_q;
                        rf_wdata_d = align_data;
                    end
                    state_d = ST_IDLE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pending-load fields and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            pend_rd_q       <= '0;
            pend_regwrite_q <= 1'b0;
            pend_size_q     <= '0;
            pend_unsigned_q <= 1'b0;
            pend_off_q      <= '0;
            rf_we_q         <= 1'b0;
            rf_waddr_q      <= '0;
            rf_wdata_q      <= '0;
        end else begin
            state_q         <= state_d;
            pend_rd_q       <= pend_rd_d;
            pend_regwrite_q <= pend_regwrite_d;
            pend_size_q     <= pend_size_d;
            pend_unsigned_q <= pend_unsigned_d;
            pend_off_q      <= pend_off_d;
            rf_we_q         <= rf_we_d;
            rf_waddr_q      <= rf_waddr_d;
            rf_wdata_q      <= rf_wdata_d;
        end
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Parametrised write-back stage for the pipelined RISC-V core. Replaces the plain memory/ALU result mux.
- Accepts one retiring instruction per cycle from MEM over a valid/ready handshake.
- Waits for variable-latency data-memory read responses and aligns and sign/zero-extends load data.
- Selects among four result sources and drives a registered register-file write port, which also serves as the forwarding source.
- Drains orphaned memory responses after a flush.

Parameters:
DATA_WIDTH, 32, register/data width; 32 or 64 only.
REG_ADDR_WIDTH, 5, register index width.
OFF_W (localparam), $clog2(DATA_WIDTH/8), byte-offset width.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  MEM presents an instruction.
in_ready  out  1  stage can accept; (state==IDLE) & ~rst.
in_regwrite  in  1  instruction writes rd.
in_rd  in  REG_ADDR_WIDTH  destination register.
in_wb_sel  in  2  result source: 0 ALU, 1 MEM, 2 PC+4, 3 CSR.
in_alu_data  in  DATA_WIDTH  ALU result.
in_pc_plus4  in  DATA_WIDTH  link value.
in_csr_data  in  DATA_WIDTH  CSR read value.
in_load_size  in  2  0 byte, 1 half, 2 word, 3 dword.
in_load_unsigned  in  1  zero-extend when 1.
in_addr_lo  in  OFF_W  low address bits of the load.
flush  in  1  kill the current or pending instruction.
mem_rvalid  in  1  read data valid this cycle.
mem_rdata  in  DATA_WIDTH  raw read word.
rf_we  out  1  register-file write enable (registered).
rf_waddr  out  REG_ADDR_WIDTH  write address (registered).
rf_wdata  out  DATA_WIDTH  write data (registered).
busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, while rst=1): state=IDLE, pending fields cleared; rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, in_ready=0.
- Accept: in_valid & in_ready at a rising edge.
- State IDLE:
  - Accept with flush=1: instruction discarded; no write; stay IDLE.
  - Accept of a non-load (wb_sel≠1): next cycle rf_we=in_regwrite & (in_rd≠0), rf_waddr=in_rd, rf_wdata=the selected source. Latency is 1 cycle.
  - Accept of a load (wb_sel=1) with mem_rvalid=1 in the same cycle: completes as for a non-load, using the aligned data.
  - Accept of a load otherwise: latch rd, regwrite, size, unsigned and offset; go to WAIT_MEM.
  - mem_rvalid in IDLE with no load accepted: ignored.
- State WAIT_MEM (in_ready=0):
  - mem_rvalid=1 & flush=0: write the aligned data with the same rules; go to IDLE.
  - flush=1 & mem_rvalid=1: discard; go to IDLE.
  - flush=1 & mem_rvalid=0: go to DRAIN.
- State DRAIN (in_ready=0, no write): wait for mem_rvalid, discard it, go to IDLE. flush has no effect in DRAIN.
- rf_we is a single-cycle pulse per completed instruction. It is 0 in every cycle with no completion.
- A load to x0 still waits for its response; rf_we stays 0.
- Load alignment: shifted = mem_rdata >> (8*in_addr_lo), then extract the low 8/16/32/64 bits and sign- or zero-extend to DATA_WIDTH.
  - Size 3 when DATA_WIDTH=32 is treated as word.
  - Word extension is a no-op at DATA_WIDTH=32.
  - Misaligned offsets are not trapped; bytes above the word are taken as zero from the shift.
- Reset asserted in WAIT_MEM or DRAIN: immediate return to IDLE. Responses arriving afterwards are ignored per the IDLE rule.

Decomposition:
- Shared package riscv_def: WB_SEL_ALU/MEM/PC4/CSR codes, LOAD_SIZE_B/H/W/D codes, FSM state encodings.
- One combinational sub-module, load_align: inputs rdata, offset, size and unsigned; output extended data. Parameterised by DATA_WIDTH.

Test Plan:
- Reset then accept ALU op: rd=5, alu=0x1234, regwrite=1 -> next cycle rf_we=1, waddr=5, wdata=0x00001234; the cycle after, rf_we=0.
- Load byte signed, offset 2, same-cycle rvalid, rdata=0x0080FF11 -> wdata=0xFFFFFF80. Unsigned half at offset 2 on the same data -> 0x00000080.
- Load with rvalid 3 cycles later -> in_ready=0 and busy=1 for those 3 cycles. rf_we fires the cycle after rvalid with the extended value.
- Load pending, flush asserted 1 cycle later, rvalid 2 cycles after that -> state goes to DRAIN, no rf_we, in_ready returns to 1 only after rvalid.
- Back-to-back non-loads to rd=0 (x0), then PC+4 to rd=1 (pc4=0x104) -> no write for x0; the rd=1 write carries 0x104, one per cycle.
- DATA_WIDTH=64: load word signed, offset 4, rdata=0x8000000012345678 -> wdata=0xFFFFFFFF80000000.
